// File: rtl/xbar_sel_cfg_pkg.sv
// Shared types for the crossbar select-map configuration stage: FSM states,
// a wide select-entry type and the identity-map helper used for reset values.
package xbar_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2
   } xbar_cfg_state_e;

   // Widest select entry supported; modules narrow it to $clog2(NumElem).
   localparam int unsigned XbarSelMaxW = 8;
   typedef logic [XbarSelMaxW-1:0] sel_wide_t;

   function automatic sel_wide_t identity_entry(input int unsigned idx);
      return sel_wide_t'(idx);
   endfunction

endpackage

// File: rtl/xbar_sel_cfg_if.sv
// Configuration port of xbar_sel_cfg: write/commit handshake, status pulses
// and the active select map that feeds the crossbar.
interface xbar_sel_cfg_if #(
   parameter int unsigned NumElem = 6
);
   localparam int unsigned SelWidth = $clog2(NumElem);

   logic                               wr_valid_i;
   logic                               wr_ready_o;
   logic [SelWidth-1:0]                wr_dest_i;
   logic [SelWidth-1:0]                wr_src_i;
   logic                               commit_i;
   logic [NumElem-1:0][SelWidth-1:0]   select_o;
   logic                               busy_o;
   logic                               wr_err_o;
   logic                               commit_done_o;
   logic                               commit_err_o;

   modport master (
      output wr_valid_i, wr_dest_i, wr_src_i, commit_i,
      input  wr_ready_o, select_o, busy_o, wr_err_o, commit_done_o, commit_err_o
   );

   modport slave (
      input  wr_valid_i, wr_dest_i, wr_src_i, commit_i,
      output wr_ready_o, select_o, busy_o, wr_err_o, commit_done_o, commit_err_o
   );
endinterface

// File: rtl/xbar_sel_cfg_perm_chk.sv
// Permutation checker: scans one shadow entry per cycle and flags a repeated source.
// Compiled only when XBAR_CFG_PERM_CHECK_EN is defined.
`ifdef XBAR_CFG_PERM_CHECK_EN
module xbar_cfg_perm_chk
   import xbar_pkg::*;
#(
   parameter int unsigned NumElem = 6
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     start_i,
   input  logic [NumElem-1:0][$clog2(NumElem)-1:0]  shadow_i,
   output logic                                     done_o,
   output logic                                     err_o
);
   localparam int unsigned SelWidth = $clog2(NumElem);

   logic                 run_q;
   logic [SelWidth-1:0]  idx_q;
   logic [NumElem-1:0]   used_q;
   logic                 dup_q;
   logic [SelWidth-1:0]  entry;
   logic                 hit;
   logic                 last;

   assign entry = shadow_i[idx_q];
   assign hit   = used_q[entry];
   assign last  = (idx_q == SelWidth'(NumElem - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_q  <= 1'b0;
         idx_q  <= '0;
         used_q <= '0;
         dup_q  <= 1'b0;
      end else if (start_i) begin
         run_q  <= 1'b1;
         idx_q  <= '0;
         used_q <= '0;
         dup_q  <= 1'b0;
      end else if (run_q) begin
         used_q[entry] <= 1'b1;
         dup_q         <= dup_q | hit;
         idx_q         <= idx_q + 1'b1;
         if (last) begin
            run_q <= 1'b0;
         end
      end
   end

   // The last entry's own collision is folded in combinationally.
   assign done_o = run_q && last;
   assign err_o  = dup_q || hit;

endmodule
`endif

// File: rtl/xbar_sel_cfg.sv
// Shadow/active select-map stage for the crossbar; commits apply atomically.
// Optional permutation check before apply: define XBAR_CFG_PERM_CHECK_EN.
module xbar_sel_cfg
   import xbar_pkg::*;
#(
   parameter int unsigned NumElem = 6
) (
   input logic            clk_i,
   input logic            rst_i,
   xbar_sel_cfg_if.slave  cfg
);
   localparam int unsigned SelWidth = $clog2(NumElem);
   typedef logic [SelWidth-1:0] sel_t;
   typedef sel_t [NumElem-1:0]  map_t;

   xbar_cfg_state_e state_q, state_d;
   map_t            shadow_q, active_q, ident;
   logic            wr_err_q, done_q;
   logic            wr_ready, busy;
   logic            wr_fire, wr_in_range, commit_fire;

   for (genvar gi = 0; gi < NumElem; gi++) begin : g_ident
      assign ident[gi] = sel_t'(identity_entry(gi));
   end

   assign wr_fire     = cfg.wr_valid_i && wr_ready;
   assign commit_fire = cfg.commit_i && wr_ready;
   assign wr_in_range = (32'(cfg.wr_dest_i) < NumElem) && (32'(cfg.wr_src_i) < NumElem);

`ifdef XBAR_CFG_PERM_CHECK_EN
   logic chk_done, chk_err;
   logic cerr_q, cerr_d;

   xbar_cfg_perm_chk #(.NumElem(NumElem)) u_perm_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (commit_fire),
      .shadow_i (shadow_q),
      .done_o   (chk_done),
      .err_o    (chk_err)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cerr_q <= 1'b0;
      else       cerr_q <= cerr_d;
   end
   assign cfg.commit_err_o = cerr_q;
`else
   assign cfg.commit_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
`ifdef XBAR_CFG_PERM_CHECK_EN
      cerr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (commit_fire) begin
`ifdef XBAR_CFG_PERM_CHECK_EN
               state_d = CHECK;
`else
               state_d = APPLY;
`endif
            end
         end
         CHECK: begin
`ifdef XBAR_CFG_PERM_CHECK_EN
            if (chk_done) begin
               if (chk_err) begin
                  state_d = IDLE;
                  cerr_d  = 1'b1;
               end else begin
                  state_d = APPLY;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ready = 1'b0;
      busy     = 1'b0;
      unique case (state_q)
         IDLE:         wr_ready = 1'b1;
         CHECK, APPLY: busy     = 1'b1;
         default:      ;
      endcase
   end

   // A write in the commit cycle lands in shadow before the scan/apply reads it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= ident;
         active_q <= ident;
         wr_err_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         if (wr_fire && wr_in_range) begin
            shadow_q[cfg.wr_dest_i] <= cfg.wr_src_i;
         end
         if (state_q == APPLY) begin
            active_q <= shadow_q;
         end
         wr_err_q <= wr_fire && !wr_in_range;
         done_q   <= (state_q == APPLY);
      end
   end

   assign cfg.wr_ready_o    = wr_ready;
   assign cfg.busy_o        = busy;
   assign cfg.wr_err_o      = wr_err_q;
   assign cfg.commit_done_o = done_q;
   assign cfg.select_o      = active_q;

endmodule

// File: tb/tb_xbar_sel_cfg.sv
// Self-checking bench for xbar_sel_cfg: table-driven writes, hand sequences for
// commit/reset corners, then randomized traffic against a lane-array model.
`timescale 1ns/1ps
module tb_xbar_sel_cfg;
   localparam int N  = 6;
   localparam int SW = 3;
`ifdef XBAR_CFG_PERM_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xbar_sel_cfg_if #(.NumElem(N)) cfg ();
   xbar_sel_cfg #(.NumElem(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .cfg   (cfg)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int shadow_m[N];
   int active_m[N];

   typedef struct {
      int dest;
      int src;
      bit exp_err;
   } wr_vec_t;
   wr_vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*SW-1:0] pack_map(input int m[N]);
      logic [N*SW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'(m[i]);
      return r;
   endfunction

   function automatic logic [N*SW-1:0] ident_map();
      int m[N];
      for (int i = 0; i < N; i++) m[i] = i;
      return pack_map(m);
   endfunction

   function automatic bit is_perm();
      int cnt[N];
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int i = 0; i < N; i++) cnt[shadow_m[i]]++;
      for (int i = 0; i < N; i++) if (cnt[i] != 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         shadow_m[i] = i;
         active_m[i] = i;
      end
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic do_write(input int d, input int s, input bit exp_err);
      cfg.wr_valid_i = 1'b1;
      cfg.wr_dest_i  = SW'(d);
      cfg.wr_src_i   = SW'(s);
      check("wr_ready_before_write", cfg.wr_ready_o, 1);
      if (d < N && s < N) shadow_m[d] = s;
      @(negedge clk);
      cfg.wr_valid_i = 1'b0;
      check("wr_err", cfg.wr_err_o, exp_err);
      $display("write dest=%0d src=%0d wr_err=%0b", d, s, cfg.wr_err_o);
   endtask

   task automatic do_commit(input bit with_wr, input int d, input int s);
      logic [N*SW-1:0] old_sel;
      bit ok;
      int exp_k, got_k;
      old_sel = pack_map(active_m);
      check("wr_ready_before_commit", cfg.wr_ready_o, 1);
      cfg.commit_i = 1'b1;
      if (with_wr) begin
         cfg.wr_valid_i = 1'b1;
         cfg.wr_dest_i  = SW'(d);
         cfg.wr_src_i   = SW'(s);
         if (d < N && s < N) shadow_m[d] = s;
      end
      ok    = CHK ? is_perm() : 1'b1;
      exp_k = CHK ? (ok ? N + 2 : N + 1) : 2;
      @(negedge clk);
      cfg.commit_i   = 1'b0;
      cfg.wr_valid_i = 1'b0;
      if (with_wr) check("commit_wr_err", cfg.wr_err_o, !(d < N && s < N));
      got_k = 0;
      for (int k = 1; k <= 20; k++) begin
         if (cfg.commit_done_o || cfg.commit_err_o) begin
            got_k = k;
            break;
         end
         check("busy_during_commit", cfg.busy_o, 1);
         check("select_held", cfg.select_o, old_sel);
         @(negedge clk);
      end
      check("commit_latency", got_k, exp_k);
      check("commit_done", cfg.commit_done_o, ok);
      check("commit_err", cfg.commit_err_o, !ok);
      check("ready_after_commit", cfg.wr_ready_o, 1);
      check("busy_after_commit", cfg.busy_o, 0);
      if (ok) active_m = shadow_m;
      check("select_after_commit", cfg.select_o, pack_map(active_m));
      $display("commit wr=%0b ok=%0b latency=%0d select=%h", with_wr, ok, got_k, cfg.select_o);
   endtask

   task automatic do_rst_commit(input int k_rst);
      bit pulse_seen;
      cfg.commit_i = 1'b1;
      @(negedge clk);
      cfg.commit_i = 1'b0;
      for (int k = 1; k < k_rst; k++) @(negedge clk);
      check("busy_before_rst", cfg.busy_o, 1);
      rst = 1'b1;
      #1;
      check("rst_select_identity", cfg.select_o, ident_map());
      check("rst_busy", cfg.busy_o, 0);
      check("rst_ready", cfg.wr_ready_o, 1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      pulse_seen = 1'b0;
      repeat (N + 4) begin
         @(negedge clk);
         if (cfg.commit_done_o || cfg.commit_err_o) pulse_seen = 1'b1;
      end
      check("no_pulse_after_rst", pulse_seen, 0);
      $display("reset during commit at sample %0d select=%h", k_rst, cfg.select_o);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int perm[N];
      int r, d, s, tmp, j;

      tbl[0] = '{0, 5, 1'b0};
      tbl[1] = '{5, 0, 1'b0};
      tbl[2] = '{6, 2, 1'b1};
      tbl[3] = '{2, 7, 1'b1};
      tbl[4] = '{7, 7, 1'b1};
      tbl[5] = '{3, 3, 1'b0};
      tbl[6] = '{4, 6, 1'b1};
      tbl[7] = '{4, 4, 1'b0};

      rst = 1'b1;
      cfg.wr_valid_i = 1'b0;
      cfg.wr_dest_i  = '0;
      cfg.wr_src_i   = '0;
      cfg.commit_i   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_select", cfg.select_o, ident_map());
      check("reset_busy", cfg.busy_o, 0);
      check("reset_ready", cfg.wr_ready_o, 1);
      check("reset_wr_err", cfg.wr_err_o, 0);
      check("reset_done", cfg.commit_done_o, 0);
      check("reset_cerr", cfg.commit_err_o, 0);

      // Table writes, then swap lanes 0 and 5 via commit.
      foreach (tbl[i]) do_write(tbl[i].dest, tbl[i].src, tbl[i].exp_err);
      do_commit(1'b0, 0, 0);
      check("lane0_after_swap", cfg.select_o[0], 5);
      check("lane5_after_swap", cfg.select_o[5], 0);
      @(negedge clk);
      check("done_one_cycle", cfg.commit_done_o, 0);

      // Duplicate source: rejected with check, fixed and re-committed.
      do_write(1, 0, 1'b0);
      do_commit(1'b0, 0, 0);
      @(negedge clk);
      check("cerr_one_cycle", cfg.commit_err_o, 0);
      do_write(1, 1, 1'b0);
      do_commit(1'b0, 0, 0);

      // Out-of-range writes leave the shadow untouched.
      do_write(6, 2, 1'b1);
      do_write(2, 7, 1'b1);
      do_commit(1'b0, 0, 0);

      // Reset in the middle of a valid commit.
      do_write(2, 3, 1'b0);
      do_write(3, 2, 1'b0);
      do_rst_commit(CHK ? 3 : 1);
      do_commit(1'b0, 0, 0);

      // Broadcast map, then back-to-back and write-with-commit cases.
      do_write(0, 3, 1'b0);
      do_write(1, 3, 1'b0);
      do_commit(1'b0, 0, 0);
      do_commit(1'b1, 1, 1);
      do_commit(1'b0, 0, 0);
      do_commit(1'b1, 2, 4);
      do_commit(1'b1, 7, 0);

      for (int it = 0; it < 120; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6) begin
            d = int'($urandom_range(0, 7));
            s = int'($urandom_range(0, 7));
            do_write(d, s, !(d < N && s < N));
         end else if (r < 8) begin
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
               j = int'($urandom_range(0, i));
               tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < N; i++) do_write(i, perm[i], 1'b0);
            do_commit(1'b0, 0, 0);
         end else begin
            do_commit(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
